csa_calc_sweep_ctrl: RTL
========================

Name: csa_calc_sweep_ctrl

Overview:
Hardware sequencer that sits directly upstream of csa_calc_logic and also consumes its result. It sweeps csa_calc_logic_in across a programmed range and runs one request/ready/reset transaction per value. Each result is compared against a masked target, and hits plus progress are reported to the AXI register side. It replaces software stepping of the calc core one value at a time.

Parameters:
AXI_DATA_WIDTH, 32, width of times, hit counter and status words
CSA_CALC_IN_WIDTH, 40, width of swept input value
CSA_CALC_OUT_WIDTH, 48, width of calc result, target and mask
TIMEOUT_CYCLES, 65535, max cycles waiting for ready before the value is abandoned

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
sweep_start  in  1  one-cycle pulse; latches config and starts the sweep when idle
sweep_abort  in  1  one-cycle pulse; stops the sweep
sweep_stop_on_hit  in  1  latched at start; 1 = finish on first hit
sweep_in_start  in  CSA_CALC_IN_WIDTH  first value
sweep_in_end  in  CSA_CALC_IN_WIDTH  last value, inclusive
sweep_times  in  AXI_DATA_WIDTH  forwarded as csa_calc_logic_times
sweep_target  in  CSA_CALC_OUT_WIDTH  expected result
sweep_mask  in  CSA_CALC_OUT_WIDTH  1 = bit compared
sweep_busy  out  1  high from start accept until done
sweep_done  out  1  one-cycle pulse at end of sweep
sweep_hit  out  1  sticky; at least one hit this sweep
sweep_hit_in  out  CSA_CALC_IN_WIDTH  input value of first hit
sweep_hit_count  out  AXI_DATA_WIDTH  hit count, saturating
sweep_cur_in  out  CSA_CALC_IN_WIDTH  value in progress
sweep_aborted  out  1  sticky; sweep ended by abort
sweep_timeout  out  1  sticky; at least one value timed out
csa_calc_logic_inuse  in  1  calc core busy
csa_calc_logic_request  out  1  one-cycle request pulse
csa_calc_logic_times  out  AXI_DATA_WIDTH  latched sweep_times
csa_calc_logic_in  out  CSA_CALC_IN_WIDTH  equals sweep_cur_in
csa_calc_logic_ready  in  1  result valid, held until reset
csa_calc_logic_out  in  CSA_CALC_OUT_WIDTH  result
csa_calc_logic_reset  out  1  one-cycle pulse that releases the calc core

Behaviour:
- Reset values: all outputs 0; state IDLE. Reset asserted mid-sweep clears everything, with no done pulse.
- Every output is registered.
- IDLE:
  - On sweep_start, latch the config, set cur = in_start, clear hit/count/aborted/timeout/hit_in, set busy = 1, go to REQ.
  - sweep_start outside IDLE is ignored.
- REQ:
  - Wait for inuse = 0.
  - Then drive request = 1 for exactly one cycle, clear the wait counter, go to WAIT.
- WAIT:
  - When ready = 1, capture out, pulse calc reset for one cycle, go to CHECK.
  - Otherwise increment the wait counter. When it reaches TIMEOUT_CYCLES, pulse calc reset, set sweep_timeout, go to NEXT with no compare.
- CHECK:
  - hit = ((captured_out ^ target) & mask) == 0. All-zero mask means every value hits.
  - On hit: increment count (saturates at all-ones). If this is the first hit, set hit_in = cur and sweep_hit = 1.
  - If hit and stop_on_hit, go to DONE; else go to NEXT.
- NEXT:
  - If cur == in_end, go to DONE.
  - Else cur = cur + 1 modulo 2^IN_W and go to REQ. If in_end < in_start, the sweep wraps through all-ones to 0.
  - in_start == in_end runs exactly one value.
- DONE: done = 1 for one cycle, busy = 0, go to IDLE. Status holds until the next start.
- Abort, sampled in REQ/WAIT/CHECK/NEXT:
  - In WAIT, pulse calc reset; in other states, no reset pulse.
  - Set sweep_aborted and go to DONE.
  - Abort has priority over ready or timeout in the same cycle.
- If start and abort arrive together in IDLE, start wins and abort is ignored.
- Minimum cost per value with ready returned immediately: REQ→WAIT→CHECK→NEXT is 4 cycles plus the calc latency.

Decomposition:
- Shared package csa_sweep_pkg: state enum (IDLE, REQ, WAIT, CHECK, NEXT, DONE) and the default TIMEOUT_CYCLES constant.
- One sub-module, csa_sweep_match: registered masked compare plus saturating hit counter.

Test Plan:
- Calc stub: out = {8'h00, in}, ready 3 cycles after request. Range 5..9, mask all-ones, target 48'h7 → count = 1, hit_in = 7, 5 requests, 5 resets, one done pulse.
- Same setup with stop_on_hit = 1 → 3 requests (5, 6, 7), done after value 7, cur_in = 7.
- in_start = 40'hFFFFFFFFFE, in_end = 1 → values FE, FF, 0, 1 in order, 4 requests.
- Stub never raises ready for value 6, TIMEOUT_CYCLES = 20 → reset pulsed 20 cycles after that request, timeout = 1, sweep continues to 9.
- Abort pulse while in WAIT on value 7 → one reset pulse, aborted = 1, done pulse, no request for value 8.
- inuse held high 10 cycles after start → request delayed until inuse falls. rst_n dropped mid-WAIT → all outputs 0 asynchronously, no done.

Source files
------------

// File: rtl/csa_sweep_pkg.sv
// Shared types and defaults for the csa_calc sweep sequencer.
package csa_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5
  } sweep_state_t;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 65535;

endpackage

// File: rtl/csa_sweep_match.sv
// Registered masked compare of a captured calc result, plus saturating hit counter.
module csa_sweep_match #(
  parameter int OUT_W = 48,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_capture,
  input  logic [OUT_W-1:0] i_result,
  input  logic [OUT_W-1:0] i_target,
  input  logic [OUT_W-1:0] i_mask,
  input  logic             i_count,
  output logic             o_match,
  output logic [CNT_W-1:0] o_count
);

  logic             r_match;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_match <= 1'b0;
      r_count <= '0;
    end else if (i_clear) begin
      r_match <= 1'b0;
      r_count <= '0;
    end else begin
      if (i_capture)
        r_match <= ((i_result ^ i_target) & i_mask) == '0;
      // count holds at all-ones instead of wrapping
      if (i_count && (r_count != '1))
        r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_match = r_match;
  assign o_count = r_count;

endmodule

// File: rtl/csa_calc_sweep_ctrl.sv
// Sweeps csa_calc_logic_in over a range, one request/ready/reset handshake per value,
// and reports masked-compare hits and progress.
module csa_calc_sweep_ctrl
  import csa_sweep_pkg::*;
#(
  parameter int          AXI_DATA_WIDTH     = 32,
  parameter int          CSA_CALC_IN_WIDTH  = 40,
  parameter int          CSA_CALC_OUT_WIDTH = 48,
  parameter int unsigned TIMEOUT_CYCLES     = TIMEOUT_CYCLES_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sweep_start,
  input  logic                          sweep_abort,
  input  logic                          sweep_stop_on_hit,
  input  logic [CSA_CALC_IN_WIDTH-1:0]  sweep_in_start,
  input  logic [CSA_CALC_IN_WIDTH-1:0]  sweep_in_end,
  input  logic [AXI_DATA_WIDTH-1:0]     sweep_times,
  input  logic [CSA_CALC_OUT_WIDTH-1:0] sweep_target,
  input  logic [CSA_CALC_OUT_WIDTH-1:0] sweep_mask,
  output logic                          sweep_busy,
  output logic                          sweep_done,
  output logic                          sweep_hit,
  output logic [CSA_CALC_IN_WIDTH-1:0]  sweep_hit_in,
  output logic [AXI_DATA_WIDTH-1:0]     sweep_hit_count,
  output logic [CSA_CALC_IN_WIDTH-1:0]  sweep_cur_in,
  output logic                          sweep_aborted,
  output logic                          sweep_timeout,
  input  logic                          csa_calc_logic_inuse,
  output logic                          csa_calc_logic_request,
  output logic [AXI_DATA_WIDTH-1:0]     csa_calc_logic_times,
  output logic [CSA_CALC_IN_WIDTH-1:0]  csa_calc_logic_in,
  input  logic                          csa_calc_logic_ready,
  input  logic [CSA_CALC_OUT_WIDTH-1:0] csa_calc_logic_out,
  output logic                          csa_calc_logic_reset
);

  localparam int                TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]   TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

  sweep_state_t r_state, w_state_next;

  logic [TO_W-1:0]               r_wait_cnt;
  logic [CSA_CALC_IN_WIDTH-1:0]  r_cur, r_end, r_hit_in;
  logic [CSA_CALC_OUT_WIDTH-1:0] r_target, r_mask;
  logic [AXI_DATA_WIDTH-1:0]     r_times;
  logic r_stop, r_busy, r_done, r_hit, r_aborted, r_timeout, r_request, r_calc_reset;

  logic w_accept, w_req, w_crst, w_capture, w_timeout, w_abort;
  logic w_hit_inc, w_adv, w_done, w_load_cnt, w_dec_cnt, w_match;
  logic [AXI_DATA_WIDTH-1:0] w_hit_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_req        = 1'b0;
    w_crst       = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    w_abort      = 1'b0;
    w_hit_inc    = 1'b0;
    w_adv        = 1'b0;
    w_done       = 1'b0;
    w_load_cnt   = 1'b0;
    w_dec_cnt    = 1'b0;
    unique case (r_state)
      ST_IDLE: if (sweep_start) begin
        w_accept     = 1'b1;
        w_state_next = ST_REQ;
      end
      ST_REQ: begin
        if (sweep_abort) begin
          w_abort      = 1'b1;
          w_state_next = ST_DONE;
        end else if (!csa_calc_logic_inuse) begin
          w_req        = 1'b1;
          w_load_cnt   = 1'b1;
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // abort outranks ready and timeout, but the core must still be released
        if (sweep_abort) begin
          w_abort      = 1'b1;
          w_crst       = 1'b1;
          w_state_next = ST_DONE;
        end else if (csa_calc_logic_ready) begin
          w_capture    = 1'b1;
          w_crst       = 1'b1;
          w_state_next = ST_CHECK;
        end else if (r_wait_cnt == '0) begin
          w_crst       = 1'b1;
          w_timeout    = 1'b1;
          w_state_next = ST_NEXT;
        end else begin
          w_dec_cnt    = 1'b1;
        end
      end
      ST_CHECK: begin
        if (sweep_abort) begin
          w_abort      = 1'b1;
          w_state_next = ST_DONE;
        end else begin
          w_hit_inc    = w_match;
          w_state_next = (w_match && r_stop) ? ST_DONE : ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (sweep_abort) begin
          w_abort      = 1'b1;
          w_state_next = ST_DONE;
        end else if (r_cur == r_end) begin
          w_state_next = ST_DONE;
        end else begin
          w_adv        = 1'b1;
          w_state_next = ST_REQ;
        end
      end
      ST_DONE: begin
        w_done       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt   <= '0;
      r_cur        <= '0;
      r_end        <= '0;
      r_hit_in     <= '0;
      r_target     <= '0;
      r_mask       <= '0;
      r_times      <= '0;
      r_stop       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_hit        <= 1'b0;
      r_aborted    <= 1'b0;
      r_timeout    <= 1'b0;
      r_request    <= 1'b0;
      r_calc_reset <= 1'b0;
    end else begin
      r_request    <= w_req;
      r_calc_reset <= w_crst;
      r_done       <= w_done;
      // wait timer counts down from TIMEOUT_CYCLES-1; zero is terminal count
      if (w_load_cnt)     r_wait_cnt <= TO_LOAD;
      else if (w_dec_cnt) r_wait_cnt <= r_wait_cnt - TO_W'(1);
      if (w_accept) begin
        r_busy    <= 1'b1;
        r_cur     <= sweep_in_start;
        r_end     <= sweep_in_end;
        r_times   <= sweep_times;
        r_target  <= sweep_target;
        r_mask    <= sweep_mask;
        r_stop    <= sweep_stop_on_hit;
        r_hit     <= 1'b0;
        r_hit_in  <= '0;
        r_aborted <= 1'b0;
        r_timeout <= 1'b0;
      end else begin
        if (w_done)    r_busy    <= 1'b0;
        if (w_abort)   r_aborted <= 1'b1;
        if (w_timeout) r_timeout <= 1'b1;
        if (w_hit_inc && !r_hit) begin
          r_hit    <= 1'b1;
          r_hit_in <= r_cur;
        end
        if (w_adv) r_cur <= r_cur + CSA_CALC_IN_WIDTH'(1);
      end
    end
  end

  csa_sweep_match #(
    .OUT_W (CSA_CALC_OUT_WIDTH),
    .CNT_W (AXI_DATA_WIDTH)
  ) u_match (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_accept),
    .i_capture (w_capture),
    .i_result  (csa_calc_logic_out),
    .i_target  (r_target),
    .i_mask    (r_mask),
    .i_count   (w_hit_inc),
    .o_match   (w_match),
    .o_count   (w_hit_count)
  );

  assign sweep_busy             = r_busy;
  assign sweep_done             = r_done;
  assign sweep_hit              = r_hit;
  assign sweep_hit_in           = r_hit_in;
  assign sweep_hit_count        = w_hit_count;
  assign sweep_cur_in           = r_cur;
  assign sweep_aborted          = r_aborted;
  assign sweep_timeout          = r_timeout;
  assign csa_calc_logic_request = r_request;
  assign csa_calc_logic_times   = r_times;
  assign csa_calc_logic_in      = r_cur;
  assign csa_calc_logic_reset   = r_calc_reset;

endmodule
